// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave receiver with open-drain ACK, START/STOP detection and byte counting
// Ports: clk/rst_in_n system clock and async active-low reset; i2c_scl bus clock in; i2c_sda open-drain bus data;
//        rx_data/rx_valid received byte and its one-cycle strobe; addr_hit/stop_det one-cycle event pulses;
//        busy high from START to STOP; byte_cnt data bytes in this transaction, saturating at 7.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h4E,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_in_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       stop_det,
  output logic       busy,
  output logic [2:0] byte_cnt
);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE} state_t;
  state_t r_state, w_state;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d, r_oe, w_oe, r_ack_on, w_ack_on;
  logic [3:0] r_bit, w_bit;
  logic [6:0] r_shift, w_shift;
  logic [7:0] w_next_shift, w_rx_data;
  logic [2:0] w_byte_cnt;
  logic w_rx_valid, w_addr_hit, w_stop_det, w_busy;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;
  assign i2c_sda = r_oe ? 1'b0 : 1'bz;
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign w_rise = w_scl & ~r_scl_d;
  assign w_fall = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_sda_d & ~w_sda;
  assign w_stop = w_scl & ~r_sda_d & w_sda;
  assign w_next_shift = {r_shift, w_sda};
  // Synchronisers reset to the idle-bus level so reset release creates no bus edges.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i2c_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i2c_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state  <= IDLE;
      r_bit    <= '0;
      r_shift  <= '0;
      r_oe     <= 1'b0;
      r_ack_on <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      addr_hit <= 1'b0;
      stop_det <= 1'b0;
      busy     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      r_state  <= w_state;
      r_bit    <= w_bit;
      r_shift  <= w_shift;
      r_oe     <= w_oe;
      r_ack_on <= w_ack_on;
      rx_data  <= w_rx_data;
      rx_valid <= w_rx_valid;
      addr_hit <= w_addr_hit;
      stop_det <= w_stop_det;
      busy     <= w_busy;
      byte_cnt <= w_byte_cnt;
    end
  end
  // Bus conditions outrank bit sampling; r_ack_on marks that the ACK low phase has begun.
  always_comb begin
    w_state    = r_state;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_oe       = r_oe;
    w_ack_on   = r_ack_on;
    w_rx_data  = rx_data;
    w_rx_valid = 1'b0;
    w_addr_hit = 1'b0;
    w_stop_det = 1'b0;
    w_busy     = busy;
    w_byte_cnt = byte_cnt;
    if (w_start) begin
      w_state    = ADDR;
      w_bit      = '0;
      w_byte_cnt = '0;
      w_busy     = 1'b1;
      w_oe       = 1'b0;
      w_ack_on   = 1'b0;
    end else if (w_stop) begin
      w_state    = IDLE;
      w_oe       = 1'b0;
      w_ack_on   = 1'b0;
      w_stop_det = 1'b1;
      w_busy     = 1'b0;
    end else if ((r_state == ADDR || r_state == DATA) && w_rise) begin
      w_shift = w_next_shift[6:0];
      w_bit   = r_bit + 4'd1;
      if (r_bit == 4'd7) begin
        w_ack_on = 1'b0;
        if (r_state == DATA) begin
          w_rx_data  = w_next_shift;
          w_rx_valid = 1'b1;
          w_byte_cnt = (byte_cnt == 3'd7) ? 3'd7 : byte_cnt + 3'd1;
          w_state    = ACK_D;
        end else begin
          w_addr_hit = (w_next_shift == {SLAVE_ADDR, 1'b0});
          w_state    = w_addr_hit ? ACK_A : IGNORE;
        end
      end
    end else if ((r_state == ACK_A || r_state == ACK_D) && w_fall) begin
      w_oe     = ~r_ack_on;
      w_ack_on = ~r_ack_on;
      w_state  = r_ack_on ? DATA : r_state;
      w_bit    = '0;
    end
  end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: directed I2C master driving transactions against a transaction-level expectation model
module tb_i2c_slave_rx;
  localparam int H = 25;
  logic clk = 1'b0, rst_in_n = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  logic [7:0] rx_data;
  logic rx_valid, addr_hit, stop_det, busy;
  logic [2:0] byte_cnt;
  i2c_slave_rx dut (
    .clk(clk), .rst_in_n(rst_in_n), .i2c_scl(scl), .i2c_sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .addr_hit(addr_hit),
    .stop_det(stop_det), .busy(busy), .byte_cnt(byte_cnt)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  int exp_hits = 0, exp_stops = 0, exp_valids = 0;
  int obs_hits = 0, obs_stops = 0, obs_valids = 0;
  int mdl_cnt = 0;
  bit mdl_busy = 0, mdl_first = 0, mdl_hit = 0, ack_win = 0, prev_valid = 0;
  logic [7:0] exp_q[$];
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_valids++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL rx_valid: unexpected pulse with rx_data 0x%0h", rx_data);
      end else chk("rx_data", rx_data, exp_q.pop_front());
    end
    if (rx_valid && prev_valid) begin
      errs++;
      $display("FAIL rx_valid_width: high 2 cycles, expected 1");
    end
    prev_valid = rx_valid;
    if (addr_hit) obs_hits++;
    if (stop_det) obs_stops++;
    if (!m_low && sda === 1'b0 && !ack_win) begin
      errs++;
      $display("FAIL sda_drive: DUT drove SDA low outside an ACK slot at %0t", $time);
    end
  end
  task automatic i2c_start();
    tick(H / 2); m_low = 1'b0;
    tick(H / 2); scl = 1'b1;
    tick(H); m_low = 1'b1;
    tick(H); scl = 1'b0;
    mdl_busy = 1; mdl_first = 1; mdl_hit = 0; mdl_cnt = 0;
    chk("busy_after_start", busy, 1);
    chk("byte_cnt_after_start", byte_cnt, 0);
  endtask
  task automatic i2c_stop();
    tick(H / 2); m_low = 1'b1;
    tick(H / 2); scl = 1'b1;
    tick(H); m_low = 1'b0;
    tick(H);
    exp_stops++; mdl_busy = 0;
    chk("busy_after_stop", busy, 0);
    chk("byte_cnt_after_stop", byte_cnt, mdl_cnt);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit rst_in_ack);
    bit exp_ack;
    if (mdl_first) begin
      mdl_hit = (b == {7'h4E, 1'b0});
      if (mdl_hit) exp_hits++;
      exp_ack = mdl_hit;
      mdl_first = 0;
    end else begin
      exp_ack = mdl_hit;
      if (mdl_hit) begin
        exp_q.push_back(b);
        exp_valids++;
        mdl_cnt = (mdl_cnt < 7) ? mdl_cnt + 1 : 7;
      end
    end
    for (int i = 7; i >= 0; i--) begin
      tick(H / 2); m_low = ~b[i];
      tick(H / 2); scl = 1'b1;
      tick(H); scl = 1'b0;
    end
    ack_win = exp_ack;
    tick(H / 2); m_low = 1'b0;
    tick(H / 2); scl = 1'b1;
    tick(H / 2);
    chk("ack", int'(sda === 1'b0), int'(exp_ack));
    if (rst_in_ack) begin
      rst_in_n = 1'b0;
      #1;
      chk("rst_sda_released", int'(sda === 1'b1), 1);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_byte_cnt", byte_cnt, 0);
      chk("rst_pulses", {rx_valid, addr_hit, stop_det}, 0);
      mdl_busy = 0; mdl_cnt = 0; mdl_hit = 0;
      tick(3);
      rst_in_n = 1'b1;
    end
    tick(H / 2); scl = 1'b0;
    tick(H / 2); ack_win = 1'b0;
    chk("byte_cnt", byte_cnt, mdl_cnt);
    chk("busy", busy, int'(mdl_busy));
  endtask
  task automatic check_counts();
    chk("addr_hit_count", obs_hits, exp_hits);
    chk("rx_valid_count", obs_valids, exp_valids);
    chk("stop_det_count", obs_stops, exp_stops);
    chk("pending_bytes", exp_q.size(), 0);
  endtask
  initial begin
    tick(3);
    chk("reset_outputs", {rx_data, rx_valid, addr_hit, stop_det, busy, byte_cnt}, 0);
    chk("reset_sda", int'(sda === 1'b1), 1);
    rst_in_n = 1'b1;
    tick(5);
    // basic write of three bytes
    i2c_start();
    send_byte(8'h9C, 0); send_byte(8'hA5, 0); send_byte(8'h3C, 0); send_byte(8'hFF, 0);
    i2c_stop();
    check_counts();
    chk("t1_rx_data", rx_data, 8'hFF);
    chk("t1_byte_cnt", byte_cnt, 3);
    chk("t1_hits", obs_hits, 1);
    chk("t1_valids", obs_valids, 3);
    chk("t1_stops", obs_stops, 1);
    // read address is ignored
    i2c_start();
    send_byte(8'h9D, 0); send_byte(8'h55, 0); send_byte(8'hAA, 0);
    i2c_stop();
    check_counts();
    chk("t2_hits", obs_hits, 1);
    chk("t2_rx_data_held", rx_data, 8'hFF);
    // repeated START
    i2c_start();
    send_byte(8'h9C, 0); send_byte(8'h11, 0);
    i2c_start();
    send_byte(8'h9C, 0); send_byte(8'h22, 0);
    i2c_stop();
    check_counts();
    chk("t3_byte_cnt", byte_cnt, 1);
    chk("t3_rx_data", rx_data, 8'h22);
    // byte count saturation
    i2c_start();
    send_byte(8'h9C, 0);
    for (int i = 0; i < 9; i++) send_byte(8'(i * 17 + 3), 0);
    i2c_stop();
    check_counts();
    chk("t4_byte_cnt", byte_cnt, 7);
    chk("t4_rx_data", rx_data, 8'h8B);
    // reset during the ACK of data byte 2, then a clean transaction
    i2c_start();
    send_byte(8'h9C, 0); send_byte(8'h01, 0); send_byte(8'h02, 1);
    tick(H);
    check_counts();
    i2c_start();
    send_byte(8'h9C, 0); send_byte(8'h77, 0);
    i2c_stop();
    check_counts();
    chk("t5_rx_data", rx_data, 8'h77);
    chk("t5_byte_cnt", byte_cnt, 1);
    // SDA glitch with SCL low, then STOP right after address ACK
    i2c_start();
    send_byte(8'h9C, 0);
    tick(H / 2); m_low = 1'b1;
    tick(1); m_low = 1'b0;
    tick(H / 2);
    chk("t6_busy_mid", busy, 1);
    i2c_stop();
    check_counts();
    chk("t6_busy", busy, 0);
    chk("t6_byte_cnt", byte_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
